alu_reservation_station: RTL and testbench

//  Integer-ALU reservation station for the OoO core: buffers dispatched int ops, wakes operands from CDB,

---
 rtl/alu_reservation_station.sv | 155 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station: buffers dispatched ops, wakes operands from the CDB, issues the
// lowest-index ready op through an issue register to the external ALU and registers its result.
module alu_reservation_station #(
  parameter int BIT_WIDTH = 64,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [3:0]           disp_op,
  input  logic                 disp_src1_rdy,
  input  logic [TAG_WIDTH-1:0] disp_src1_tag,
  input  logic [BIT_WIDTH-1:0] disp_src1_val,
  input  logic                 disp_src2_rdy,
  input  logic [TAG_WIDTH-1:0] disp_src2_tag,
  input  logic [BIT_WIDTH-1:0] disp_src2_val,
  input  logic [TAG_WIDTH-1:0] disp_dst_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [BIT_WIDTH-1:0] cdb_data,
  output logic [BIT_WIDTH-1:0] alu_in1,
  output logic [BIT_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_op,
  input  logic [BIT_WIDTH-1:0] alu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic [BIT_WIDTH-1:0] res_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]     e_valid;
  logic [DEPTH-1:0]     e_s1_rdy;
  logic [DEPTH-1:0]     e_s2_rdy;
  logic [3:0]           e_op     [DEPTH];
  logic [TAG_WIDTH-1:0] e_s1_tag [DEPTH];
  logic [TAG_WIDTH-1:0] e_s2_tag [DEPTH];
  logic [TAG_WIDTH-1:0] e_dst    [DEPTH];
  logic [BIT_WIDTH-1:0] e_s1_val [DEPTH];
  logic [BIT_WIDTH-1:0] e_s2_val [DEPTH];

  logic                 iss_valid;
  logic [TAG_WIDTH-1:0] iss_tag;

  logic [DEPTH-1:0] e_ready;
  logic             free_found, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             advance, disp_fire, issue_fire;
  logic             byp1, byp2;

  assign e_ready = e_valid & e_s1_rdy & e_s2_rdy;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (e_ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Result handshake: res_valid/res_tag/res_data hold while res_valid & !res_ready; a transfer happens
  // on res_valid & res_ready and the next result may load on that same edge.
  assign advance    = !res_valid || res_ready;
  assign disp_ready = free_found;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = advance && sel_found && !flush;
  assign byp1       = cdb_valid && !disp_src1_rdy && (cdb_tag == disp_src1_tag);
  assign byp2       = cdb_valid && !disp_src2_rdy && (cdb_tag == disp_src2_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid  <= '0;
      e_s1_rdy <= '0;
      e_s2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]     <= '0;
        e_s1_tag[i] <= '0;
        e_s2_tag[i] <= '0;
        e_dst[i]    <= '0;
        e_s1_val[i] <= '0;
        e_s2_val[i] <= '0;
      end
    end else if (flush) begin
      e_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && e_valid[i] && !e_s1_rdy[i] && (e_s1_tag[i] == cdb_tag)) begin
          e_s1_rdy[i] <= 1'b1;
          e_s1_val[i] <= cdb_data;
        end
        if (cdb_valid && e_valid[i] && !e_s2_rdy[i] && (e_s2_tag[i] == cdb_tag)) begin
          e_s2_rdy[i] <= 1'b1;
          e_s2_val[i] <= cdb_data;
        end
      end
      if (issue_fire) e_valid[sel_idx] <= 1'b0;
      // The free slot is never the issuing slot: both are chosen from the registered valid bits.
      if (disp_fire) begin
        e_valid[free_idx]  <= 1'b1;
        e_op[free_idx]     <= disp_op;
        e_dst[free_idx]    <= disp_dst_tag;
        e_s1_tag[free_idx] <= disp_src1_tag;
        e_s2_tag[free_idx] <= disp_src2_tag;
        e_s1_rdy[free_idx] <= disp_src1_rdy || byp1;
        e_s2_rdy[free_idx] <= disp_src2_rdy || byp2;
        e_s1_val[free_idx] <= byp1 ? cdb_data : disp_src1_val;
        e_s2_val[free_idx] <= byp2 ? cdb_data : disp_src2_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
      res_valid <= 1'b0;
    end else if (advance) begin
      iss_valid <= sel_found;
      if (sel_found) begin
        alu_in1 <= e_s1_val[sel_idx];
        alu_in2 <= e_s2_val[sel_idx];
        alu_op  <= e_op[sel_idx];
        iss_tag <= e_dst[sel_idx];
      end
      res_valid <= iss_valid;
      if (iss_valid) begin
        res_tag  <= iss_tag;
        res_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed latency/backpressure/flush/reset steps, then random
// traffic checked against a tag-indexed operand model and a stub ALU.
module tb_alu_reservation_station;

  localparam int BW = 64;
  localparam int DEPTH = 4;
  localparam int TW = 6;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [3:0]    disp_op = '0;
  logic          disp_src1_rdy = 1'b0;
  logic [TW-1:0] disp_src1_tag = '0;
  logic [BW-1:0] disp_src1_val = '0;
  logic          disp_src2_rdy = 1'b0;
  logic [TW-1:0] disp_src2_tag = '0;
  logic [BW-1:0] disp_src2_val = '0;
  logic [TW-1:0] disp_dst_tag = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [BW-1:0] cdb_data = '0;
  logic [BW-1:0] alu_in1, alu_in2, alu_result;
  logic [3:0]    alu_op;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [TW-1:0] res_tag;
  logic [BW-1:0] res_data;

  int n_asserts = 0;
  int n_fail = 0;

  // scoreboard: ordered expectations {tag,data} for directed steps
  logic [TW+BW-1:0] exp_q[$];

  // random-phase model, indexed by destination tag
  logic          p_valid [32];
  logic [3:0]    p_op    [32];
  logic [BW-1:0] p_a     [32];
  logic [BW-1:0] p_b     [32];
  logic [TW-1:0] p_ta    [32];
  logic [TW-1:0] p_tb    [32];
  logic          p_ka    [32];
  logic          p_kb    [32];
  logic [TW-1:0] wake_q[$];
  logic [TW-1:0] next_wake = 6'd32;
  int            n_pend = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
    .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data)
  );

  function automatic logic [BW-1:0] alu_model(input logic [3:0] op, input logic [BW-1:0] a,
                                               input logic [BW-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[5:0];
      4'd6: return a >> b[5:0];
      4'd7: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_op, alu_in1, alu_in2);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic r1, input logic [TW-1:0] t1,
                          input logic [BW-1:0] v1, input logic r2, input logic [TW-1:0] t2,
                          input logic [BW-1:0] v2, input logic [TW-1:0] dst);
    disp_valid = 1'b1;
    disp_op = op;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_dst_tag = dst;
  endtask

  task automatic set_cdb(input logic v, input logic [TW-1:0] t, input logic [BW-1:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({pfx, "_res_tag"}, 64'(res_tag), 64'd0);
    chk({pfx, "_res_data"}, res_data, 64'd0);
    chk({pfx, "_alu_in1"}, alu_in1, 64'd0);
    chk({pfx, "_alu_in2"}, alu_in2, 64'd0);
    chk({pfx, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({pfx, "_disp_ready"}, 64'(disp_ready), 64'd1);
  endtask

  task automatic alloc_wake(output logic [TW-1:0] t);
    t = next_wake;
    next_wake = (next_wake == 6'd63) ? 6'd32 : next_wake + 6'd1;
    wake_q.push_back(t);
  endtask

  task automatic model_cdb(input logic [TW-1:0] t, input logic [BW-1:0] d);
    for (int i = 0; i < 32; i++) begin
      if (p_valid[i] && !p_ka[i] && p_ta[i] == t) begin p_a[i] = d; p_ka[i] = 1'b1; end
      if (p_valid[i] && !p_kb[i] && p_tb[i] == t) begin p_b[i] = d; p_kb[i] = 1'b1; end
    end
  endtask

  task automatic consume();
    logic [4:0] idx;
    idx = res_tag[4:0];
    chk("rnd_tag_range", 64'(res_tag[5]), 64'd0);
    chk("rnd_pending", 64'(p_valid[idx]), 64'd1);
    chk("rnd_srcs_known", 64'(p_ka[idx] & p_kb[idx]), 64'd1);
    chk("rnd_data", res_data, alu_model(p_op[idx], p_a[idx], p_b[idx]));
    if (p_valid[idx]) begin
      p_valid[idx] = 1'b0;
      n_pend--;
    end
  endtask

  initial begin
    logic [TW+BW-1:0] e;
    logic             stall_prev;
    logic [TW-1:0]    prev_tag;
    logic [BW-1:0]    prev_data;
    int               seq;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD 5+7 -> tag 3, result three cycles after dispatch
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd7, 6'd3);
    tick();
    disp_valid = 1'b0;
    chk("t1_res_valid_n1", 64'(res_valid), 64'd0);
    tick();
    chk("t1_alu_in1", alu_in1, 64'd5);
    chk("t1_alu_in2", alu_in2, 64'd7);
    chk("t1_alu_op", 64'(alu_op), 64'(OP_ADD));
    chk("t1_res_valid_n2", 64'(res_valid), 64'd0);
    tick();
    chk("t1_res_valid", 64'(res_valid), 64'd1);
    chk("t1_res_tag", 64'(res_tag), 64'd3);
    chk("t1_res_data", res_data, 64'd12);
    tick();
    chk("t1_drained", 64'(res_valid), 64'd0);

    // SUB with src1 woken by CDB two cycles after dispatch
    set_disp(OP_SUB, 1'b0, 6'd9, 64'hdead, 1'b1, 6'd0, 64'd1, 6'd5);
    tick();
    disp_valid = 1'b0;
    tick();
    set_cdb(1'b1, 6'd9, 64'd10);
    tick();
    cdb_valid = 1'b0;
    chk("t2a_wait1", 64'(res_valid), 64'd0);
    tick();
    chk("t2a_wait2", 64'(res_valid), 64'd0);
    tick();
    chk("t2a_res_valid", 64'(res_valid), 64'd1);
    chk("t2a_res_tag", 64'(res_tag), 64'd5);
    chk("t2a_res_data", res_data, 64'd9);
    tick();

    // same op with CDB in the dispatch cycle: bypass, no extra latency
    set_disp(OP_SUB, 1'b0, 6'd9, 64'hbeef, 1'b1, 6'd0, 64'd1, 6'd6);
    set_cdb(1'b1, 6'd9, 64'd10);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b0;
    chk("t2b_wait1", 64'(res_valid), 64'd0);
    tick();
    chk("t2b_wait2", 64'(res_valid), 64'd0);
    tick();
    chk("t2b_res_valid", 64'(res_valid), 64'd1);
    chk("t2b_res_tag", 64'(res_tag), 64'd6);
    chk("t2b_res_data", res_data, 64'd9);
    tick();

    // AND with both sources on the same tag
    set_disp(OP_AND, 1'b0, 6'd4, 64'hff, 1'b0, 6'd4, 64'hf0, 6'd7);
    tick();
    disp_valid = 1'b0;
    set_cdb(1'b1, 6'd4, 64'd6);
    tick();
    cdb_valid = 1'b0;
    tick();
    tick();
    chk("t6_res_valid", 64'(res_valid), 64'd1);
    chk("t6_res_tag", 64'(res_tag), 64'd7);
    chk("t6_res_data", res_data, 64'd6);
    tick();

    // fill all entries with unready ops; fifth dispatch is refused
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_fill_ready", 64'(disp_ready), 64'd1);
      set_disp(OP_ADD, 1'b0, 6'(20 + i), 64'd0, 1'b1, 6'd0, 64'(100 + i), 6'(10 + i));
      tick();
    end
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd50, 1'b1, 6'd0, 64'd50, 6'd15);
    chk("t3_full", 64'(disp_ready), 64'd0);
    tick();
    tick();
    disp_valid = 1'b0;
    chk("t3_still_full", 64'(disp_ready), 64'd0);
    chk("t3_no_result", 64'(res_valid), 64'd0);
    set_cdb(1'b1, 6'd22, 64'd7);
    tick();
    cdb_valid = 1'b0;
    chk("t3_ready_before_sel", 64'(disp_ready), 64'd0);
    tick();
    chk("t3_ready_after_sel", 64'(disp_ready), 64'd1);
    chk("t3_alu_in1", alu_in1, 64'd7);
    chk("t3_alu_in2", alu_in2, 64'd102);
    tick();
    chk("t3_res_valid", 64'(res_valid), 64'd1);
    chk("t3_res_tag", 64'(res_tag), 64'd12);
    chk("t3_res_data", res_data, 64'd109);
    tick();
    chk("t3_refused_not_written", 64'(res_valid), 64'd0);

    // backpressure with three ready entries, then release in entry-index order
    res_ready = 1'b0;
    set_cdb(1'b1, 6'd20, 64'd1);
    tick();
    set_cdb(1'b1, 6'd21, 64'd2);
    tick();
    set_cdb(1'b1, 6'd23, 64'd3);
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(res_valid), 64'd1);
      chk("t4_hold_tag", 64'(res_tag), 64'd10);
      chk("t4_hold_data", res_data, 64'd101);
      tick();
    end
    exp_q.push_back({6'd10, 64'd101});
    exp_q.push_back({6'd11, 64'd103});
    exp_q.push_back({6'd13, 64'd106});
    res_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("t4_rel_valid", 64'(res_valid), 64'd1);
      chk("t4_rel_tag", 64'(res_tag), 64'(e[TW+BW-1:BW]));
      chk("t4_rel_data", res_data, e[BW-1:0]);
      tick();
    end
    chk("t4_empty", 64'(res_valid), 64'd0);

    // flush with entries, issue reg and result reg all occupied
    res_ready = 1'b0;
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 64'd1, 6'd20);
    tick();
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd2, 1'b1, 6'd0, 64'd2, 6'd21);
    tick();
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd3, 1'b1, 6'd0, 64'd3, 6'd22);
    tick();
    set_disp(OP_ADD, 1'b0, 6'd30, 64'd0, 1'b1, 6'd0, 64'd4, 6'd23);
    tick();
    chk("t5_pre_flush_valid", 64'(res_valid), 64'd1);
    flush = 1'b1;
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd9, 1'b1, 6'd0, 64'd9, 6'd25);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk("t5_flush_res_valid", 64'(res_valid), 64'd0);
    chk("t5_flush_disp_ready", 64'(disp_ready), 64'd1);
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_result_after_flush", 64'(res_valid), 64'd0);
    end

    // async reset pulse mid-stream
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd3, 1'b1, 6'd0, 64'd4, 6'd24);
    tick();
    set_disp(OP_ADD, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd6, 6'd26);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("t5_pre_rst_valid", 64'(res_valid), 64'd1);
    chk("t5_pre_rst_data", res_data, 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_no_result_after_rst", 64'(res_valid), 64'd0);
    end

    // random traffic
    for (int i = 0; i < 32; i++) p_valid[i] = 1'b0;
    stall_prev = 1'b0;
    prev_tag = '0;
    prev_data = '0;
    seq = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (stall_prev) begin
        chk("rnd_hold_valid", 64'(res_valid), 64'd1);
        chk("rnd_hold_tag", 64'(res_tag), 64'(prev_tag));
        chk("rnd_hold_data", res_data, prev_data);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready) consume();
      stall_prev = res_valid && !res_ready;
      prev_tag = res_tag;
      prev_data = res_data;

      disp_valid = 1'b0;
      if (disp_ready && $urandom_range(0, 2) != 0) begin
        logic [4:0]    d;
        logic          r1, r2;
        logic [TW-1:0] t1, t2;
        logic [BW-1:0] v1, v2;
        logic [3:0]    op;
        d = 5'(seq % 32);
        seq++;
        op = 4'($urandom_range(0, 7));
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom};
        r1 = (wake_q.size() < 6) ? ($urandom_range(0, 2) != 0) : 1'b1;
        r2 = (wake_q.size() < 6) ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (r1) t1 = 6'($urandom_range(0, 63));
        else alloc_wake(t1);
        if (r2) t2 = 6'($urandom_range(0, 63));
        else if (!r1 && $urandom_range(0, 3) == 0) t2 = t1;
        else alloc_wake(t2);
        set_disp(op, r1, t1, v1, r2, t2, v2, {1'b0, d});
        p_valid[d] = 1'b1; p_op[d] = op;
        p_a[d] = v1; p_b[d] = v2; p_ta[d] = t1; p_tb[d] = t2; p_ka[d] = r1; p_kb[d] = r2;
        n_pend++;
      end

      if (wake_q.size() > 0 && $urandom_range(0, 1) != 0) begin
        logic [TW-1:0] wt;
        logic [BW-1:0] wd;
        wt = wake_q.pop_front();
        wd = {$urandom, $urandom};
        set_cdb(1'b1, wt, wd);
        model_cdb(wt, wd);
      end else begin
        set_cdb(1'b0, 6'($urandom_range(0, 63)), {$urandom, $urandom});
      end
      tick();
    end

    // drain: wake everything still waiting and collect all results
    disp_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 300 && n_pend > 0; k++) begin
      if (res_valid) consume();
      if (wake_q.size() > 0) begin
        logic [TW-1:0] wt;
        logic [BW-1:0] wd;
        wt = wake_q.pop_front();
        wd = {$urandom, $urandom};
        set_cdb(1'b1, wt, wd);
        model_cdb(wt, wd);
      end else begin
        cdb_valid = 1'b0;
      end
      tick();
    end
    cdb_valid = 1'b0;
    chk("rnd_drain_complete", 64'(n_pend), 64'd0);
    chk("rnd_final_disp_ready", 64'(disp_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
